// File: rtl/dsp_dot_sequencer.sv
// ---------------------------------------------------------------------------
// dsp_dot_sequencer
//
// Runs one DSP slice (CONTROLREG=0, no pre-adder) as a signed dot-product
// engine. A command supplies a vector length and a 48-bit bias. Operand pairs
// are then streamed in, and per-cycle OPMODE words steer the slice so that
// P = bias + sum(A*B). The final P is handed back over a valid/ready port.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, len, bias    command strobe (taken only when idle), pair count,
//                       initial accumulator value
//   busy                high whenever a command is in progress
//   in_valid/in_ready   operand pair handshake
//   in_a, in_b          signed operands
//   dsp_A/B/C           registered operands and bias driven to the slice
//   dsp_opmode          OPMODE, delayed so it meets its operands at the ALU
//   dsp_alumode         constant 0 (Z + W + X + Y)
//   dsp_inmode          constant 0
//   dsp_P               slice P output
//   res_valid/res_ready result handshake
//   res_data            48-bit signed result
//
// States
//   state  | meaning
//   IDLE   | waiting for start
//   STREAM | accepting operand pairs, counter = pairs still to come
//   DRAIN  | last pair issued, waiting for it to reach the P register
//   DONE   | result presented on res_data until consumed
// ---------------------------------------------------------------------------
module dsp_dot_sequencer #(
    parameter int A_W      = 27,
    parameter int B_W      = 18,
    parameter int LEN_W    = 10,
    parameter int IN_REG   = 1,
    parameter int PIPE_REG = 1,
    parameter int OUT_REG  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [47:0]      bias,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic [29:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic [47:0]      dsp_C,
    output logic [8:0]       dsp_opmode,
    output logic [3:0]       dsp_alumode,
    output logic [4:0]       dsp_inmode,
    input  logic [47:0]      dsp_P,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data
);

    // The accumulation feeds P back through Z, which only exists when the
    // slice has its output register.
    if (OUT_REG != 1) begin : g_bad_out_reg
        $error("dsp_dot_sequencer: OUT_REG must be 1 for P feedback");
    end

    // Edges from the last accept until dsp_P carries the final sum.
    localparam int LAT = 1 + IN_REG + PIPE_REG + OUT_REG;
    // OPMODE is combinational at the ALU, so it must trail dsp_A/dsp_B by the
    // slice's input and multiplier register stages.
    localparam int DLY = IN_REG + PIPE_REG;

    localparam logic [2:0] DRAIN_LOAD = 3'(LAT - 1);

    localparam logic [8:0] OP_FIRST = 9'b110000101;  // P = C + M
    localparam logic [8:0] OP_ACC   = 9'b000100101;  // P = P + M
    localparam logic [8:0] OP_HOLD  = 9'b000100000;  // P = P
    localparam logic [8:0] OP_ZERO  = 9'b000000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] pair_cnt;
    logic [2:0]       drain_cnt;
    logic             first_seen;
    logic [8:0]       op_issue;
    logic             accept;

    assign dsp_alumode = 4'b0000;
    assign dsp_inmode  = 5'b00000;

    assign accept = (state == STREAM) && in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pair_cnt   <= '0;
            drain_cnt  <= '0;
            first_seen <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            dsp_A      <= '0;
            dsp_B      <= '0;
            dsp_C      <= '0;
            op_issue   <= OP_ZERO;
        end else begin
            // Operands are zero unless a pair is taken this cycle.
            dsp_A    <= '0;
            dsp_B    <= '0;
            op_issue <= OP_ZERO;

            case (state)
                IDLE: begin
                    if (start) begin
                        pair_cnt   <= len;
                        dsp_C      <= bias;
                        first_seen <= 1'b0;
                        busy       <= 1'b1;
                        if (len != '0) begin
                            state    <= STREAM;
                            in_ready <= 1'b1;
                        end else begin
                            // Empty vector: the bias is the answer, the slice
                            // is never touched.
                            res_data  <= bias;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                STREAM: begin
                    if (accept) begin
                        dsp_A      <= 30'($signed(in_a));
                        dsp_B      <= 18'($signed(in_b));
                        op_issue   <= first_seen ? OP_ACC : OP_FIRST;
                        first_seen <= 1'b1;
                        pair_cnt   <= pair_cnt - 1'b1;
                        if (pair_cnt == LEN_W'(1)) begin
                            in_ready  <= 1'b0;
                            drain_cnt <= DRAIN_LOAD;
                            state     <= DRAIN;
                        end
                    end else begin
                        // A bubble after the first pair must keep P intact.
                        op_issue <= first_seen ? OP_HOLD : OP_ZERO;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        res_data  <= dsp_P;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    if (DLY == 0) begin : g_op_nodly
        assign dsp_opmode = op_issue;
    end else begin : g_op_dly
        logic [8:0] op_sr [DLY];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DLY; i++) begin
                    op_sr[i] <= OP_ZERO;
                end
            end else begin
                op_sr[0] <= op_issue;
                for (int i = 1; i < DLY; i++) begin
                    op_sr[i] <= op_sr[i-1];
                end
            end
        end

        assign dsp_opmode = op_sr[DLY-1];
    end

endmodule
